// File: rtl/gcd_share_ctrl_pkg.sv
// Shared types and helpers for the shared-gcd controller.
package gcd_share_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Index/counter width for n distinct values; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching upward from ptr.
module gcd_rr_arbiter
    import gcd_share_ctrl_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic          found;
    logic [IW-1:0] pos;

    // First active request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            pos = IW'((int'(ptr) + i) % int'(NREQ));
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                grant_idx  = pos;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_share_ctrl.sv
// Shares one gcd core among NREQ requesters: round-robin accept, core
// clear/start/done sequencing, zero-operand bypass and hang timeout.
module gcd_share_ctrl
    import gcd_share_ctrl_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned Dw      = 32,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*Dw-1:0] req_in1,
    input  logic [NREQ*Dw-1:0] req_in2,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    resp_valid,
    output logic [Dw-1:0]      resp_data,
    output logic               resp_err,
    input  logic [NREQ-1:0]    resp_ready,
    output logic               gcd_reset,
    output logic               gcd_en,
    output logic [Dw-1:0]      gcd_in1,
    output logic [Dw-1:0]      gcd_in2,
    input  logic               gcd_done,
    input  logic [Dw-1:0]      gcd_result
);

    localparam int unsigned IW    = idx_width(NREQ);
    localparam int unsigned CNT_W = idx_width(TIMEOUT);

    state_t          state, state_d;
    logic [IW-1:0]   owner, owner_d, rr_ptr, rr_ptr_d, grant_idx;
    logic [NREQ-1:0] grant, resp_valid_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [Dw-1:0]   sel_in1, sel_in2, resp_data_d, gcd_in1_d, gcd_in2_d;
    logic            resp_err_d, gcd_reset_d, gcd_en_d;

    gcd_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Accept strobe exists only in IDLE and never while reset is held.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;

    // Operand mux for the granted requester.
    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                sel_in1 = req_in1[i*Dw +: Dw];
                sel_in2 = req_in2[i*Dw +: Dw];
            end
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        rr_ptr_d     = rr_ptr;
        cnt_d        = cnt;
        resp_valid_d = resp_valid;
        resp_data_d  = resp_data;
        resp_err_d   = resp_err;
        gcd_in1_d    = gcd_in1;
        gcd_in2_d    = gcd_in2;
        gcd_reset_d  = 1'b0;
        gcd_en_d     = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    owner_d   = grant_idx;
                    gcd_in1_d = sel_in1;
                    gcd_in2_d = sel_in2;
                    rr_ptr_d  = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
                    if (sel_in1 == '0 || sel_in2 == '0) begin
                        // gcd(x,0) = x, gcd(0,0) = 0; the core is bypassed.
                        resp_data_d  = (sel_in1 == '0) ? sel_in2 : sel_in1;
                        resp_err_d   = 1'b0;
                        resp_valid_d = grant;
                        state_d      = RESP;
                    end else begin
                        gcd_reset_d = 1'b1;
                        state_d     = CLEAR;
                    end
                end
            end
            CLEAR: begin
                gcd_en_d = 1'b1;
                state_d  = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (gcd_done) begin
                    resp_data_d  = gcd_result;
                    resp_err_d   = 1'b0;
                    resp_valid_d = NREQ'(1) << owner;
                    state_d      = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = NREQ'(1) << owner;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready[owner]) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset holds the core in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            cnt        <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            gcd_in1    <= '0;
            gcd_in2    <= '0;
            gcd_reset  <= 1'b1;
            gcd_en     <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            rr_ptr     <= rr_ptr_d;
            cnt        <= cnt_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            resp_err   <= resp_err_d;
            gcd_in1    <= gcd_in1_d;
            gcd_in2    <= gcd_in2_d;
            gcd_reset  <= gcd_reset_d;
            gcd_en     <= gcd_en_d;
        end
    end

endmodule
